// File: rtl/pp_serial_loader.sv
// Operand loader and result checker for the serial partial-product harness around the
// N x N bit-heap compressor. It streams the AND heap into free-running column shift registers.
module pp_serial_loader #(
    parameter int unsigned N            = 16,
    parameter int unsigned COMP_LATENCY = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-2:0] bit_out,
    input  logic [2*N-1:0] product_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic [2*N-1:0] expected,
    output logic           err
);

    localparam int          NI    = int'(N);
    localparam int unsigned TW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WW    = (COMP_LATENCY > 0) ? $clog2(COMP_LATENCY + 1) : 1;
    localparam logic [TW-1:0] TLast = TW'(N - 1);
    localparam logic [WW-1:0] WLast = WW'(COMP_LATENCY);

    typedef enum logic [1:0] {StIdle, StShift, StWait, StHold} state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    logic [WW-1:0]  w_q, w_d;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] product_q, expected_q;
    logic           out_valid_q, out_valid_d;
    logic           err_q;
    logic           accept, capture, shifting;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        accept      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    t_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                t_d = t_q + TW'(1);
                if (t_q == TLast) begin
                    t_d     = '0;
                    w_d     = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                w_d = w_q + WW'(1);
                // Compressor output is valid COMP_LATENCY cycles after the heap completes
                if (w_q == WLast) begin
                    capture     = 1'b1;
                    w_d         = '0;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            t_q         <= '0;
            w_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            product_q   <= '0;
            expected_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                a_q        <= a;
                b_q        <= b;
                expected_q <= {{N{1'b0}}, a} * {{N{1'b0}}, b};
            end
            if (capture) begin
                product_q <= product_in;
                err_q     <= err_q | (product_in != expected_q);
            end
        end
    end

    assign shifting = (state_q == StShift) && !rst;

    // Column k loads its h_k partial products in the last h_k shift slots; earlier slots
    // shift zeros that fall off the end of the h_k-deep register.
    for (genvar k = 0; k < 2 * NI - 1; k++) begin : g_col
        localparam int Jlo   = (k >= NI) ? k - NI + 1 : 0;
        localparam int H     = (k < NI) ? k + 1 : 2 * NI - 1 - k;
        localparam int Start = NI - H;

        logic [N-1:0] slot;

        for (genvar i = 0; i < NI; i++) begin : g_slot
            if (i >= Start) begin : g_pp
                localparam int J = Jlo + i - Start;
                assign slot[i] = a_q[k-J] & b_q[J];
            end else begin : g_zero
                assign slot[i] = 1'b0;
            end
        end

        assign bit_out[k] = shifting & slot[t_q];
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign expected  = expected_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pp_serial_loader.sv
// Directed bench for pp_serial_loader with a column shift-register and compressor model,
// one instance with a combinational compressor and one with a 2-stage pipelined compressor.
module tb_pp_serial_loader;

    localparam int N = 16;
    localparam int W = 2 * N;
    localparam int C = 2 * N - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic         in_ready0, out_valid0, err0;
    logic [N-1:0] a0 = '0, b0 = '0;
    logic [C-1:0] bit_out0;
    logic [W-1:0] product_in0, product0, expected0;

    logic         in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic         in_ready2, out_valid2, err2;
    logic [N-1:0] a2 = '0, b2 = '0;
    logic [C-1:0] bit_out2;
    logic [W-1:0] product_in2, product2, expected2;

    logic [C-1:0][N-1:0] sr0 = '0;
    logic [C-1:0][N-1:0] sr2 = '0;
    logic [W-1:0]        pipe1 = '0, pipe2 = '0;
    logic                flip = 1'b0;

    logic [N-1:0] tr0, tr15, tr30;
    logic [C-1:0] wait_bits;

    int n_checks = 0;
    int n_errors = 0;

    pp_serial_loader #(.N(N), .COMP_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
        .bit_out(bit_out0), .product_in(product_in0), .out_valid(out_valid0),
        .out_ready(out_ready0), .product(product0), .expected(expected0), .err(err0)
    );

    pp_serial_loader #(.N(N), .COMP_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .bit_out(bit_out2), .product_in(product_in2), .out_valid(out_valid2),
        .out_ready(out_ready2), .product(product2), .expected(expected2), .err(err2)
    );

    function automatic int col_h(input int k);
        return (k < N) ? k + 1 : 2 * N - 1 - k;
    endfunction

    function automatic logic [N-1:0] hmask(input int k);
        logic [N-1:0] m;
        m = '1;
        return m >> (N - col_h(k));
    endfunction

    function automatic logic [W-1:0] heap_sum(input logic [C-1:0][N-1:0] h);
        logic [W-1:0] s;
        logic [W-1:0] one;
        s   = '0;
        one = W'(1);
        for (int k = 0; k < C; k++)
            for (int i = 0; i < N; i++)
                if (h[k][i]) s = s + (one << k);
        return s;
    endfunction

    // Free-running column shift registers, h_k deep, as in the harness
    always @(posedge clk) begin
        for (int k = 0; k < C; k++) begin
            sr0[k] <= ((sr0[k] << 1) | N'(bit_out0[k])) & hmask(k);
            sr2[k] <= ((sr2[k] << 1) | N'(bit_out2[k])) & hmask(k);
        end
        pipe1 <= heap_sum(sr2);
        pipe2 <= pipe1;
    end

    assign product_in0 = heap_sum(sr0) ^ (flip ? W'(8) : W'(0));
    assign product_in2 = pipe2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge just after the accept edge; returns clocks until out_valid
    task automatic wait_valid0(output int cyc);
        cyc = 0;
        tr0 = '0;
        tr15 = '0;
        tr30 = '0;
        wait_bits = '1;
        while (!out_valid0 && cyc < 100) begin
            if (cyc < N) begin
                tr0[cyc]  = bit_out0[0];
                tr15[cyc] = bit_out0[15];
                tr30[cyc] = bit_out0[30];
            end
            if (cyc == N) wait_bits = bit_out0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start0(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic rdy,
                          output int cyc);
        a0 = ta;
        b0 = tb;
        in_valid0 = 1'b1;
        out_ready0 = rdy;
        @(negedge clk);
        in_valid0 = 1'b0;
        wait_valid0(cyc);
    endtask

    task automatic do_txn(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic [W-1:0] exp_p, input logic [W-1:0] exp_ref,
                          input logic exp_err);
        int cyc;
        check({tag, " in_ready"}, in_ready0, 1);
        start0(ta, tb, 1'b1, cyc);
        check({tag, " latency"}, cyc, N + 1);
        check({tag, " product"}, product0, exp_p);
        check({tag, " expected"}, expected0, exp_ref);
        check({tag, " err"}, err0, exp_err);
        @(negedge clk);
        check({tag, " out_valid drop"}, out_valid0, 0);
    endtask

    initial begin
        int cyc;
        int seen;

        repeat (3) @(negedge clk);
        check("rst in_ready", in_ready0, 1);
        check("rst out_valid", out_valid0, 0);
        check("rst bit_out", bit_out0, 0);
        check("rst product", product0, 0);
        check("rst expected", expected0, 0);
        check("rst err", err0, 0);
        check("rst in_ready2", in_ready2, 1);
        rst = 1'b0;
        @(negedge clk);

        do_txn("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'hFFFE0001, 1'b0);
        do_txn("1234x5678", 16'h1234, 16'h5678, 32'h06260060, 32'h06260060, 1'b0);
        do_txn("0xbeef", 16'h0000, 16'hBEEF, 32'h0, 32'h0, 1'b0);

        // Result held while out_ready is low; a waiting operand pair is not taken
        start0(16'h0003, 16'h0007, 1'b0, cyc);
        check("hold latency", cyc, N + 1);
        a0 = 16'h00FF;
        b0 = 16'h0101;
        in_valid0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold in_ready", in_ready0, 0);
            check("hold out_valid", out_valid0, 1);
            check("hold product", product0, 32'h15);
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        check("hold release in_ready", in_ready0, 1);
        check("hold release out_valid", out_valid0, 0);
        @(negedge clk);
        in_valid0 = 1'b0;
        check("second accepted", in_ready0, 0);
        wait_valid0(cyc);
        check("second latency", cyc, N + 1);
        check("second product", product0, 32'h0000FFFF);
        check("second expected", expected0, 32'h0000FFFF);
        @(negedge clk);

        do_txn("8001", 16'h8001, 16'h8001, 32'h40010001, 32'h40010001, 1'b0);
        check("col0 trace", tr0, 16'h8000);
        check("col30 trace", tr30, 16'h8000);
        check("col15 trace", tr15, 16'h8001);
        check("wait bit_out", wait_bits, 0);

        flip = 1'b1;
        do_txn("flip", 16'h1234, 16'h5678, 32'h06260068, 32'h06260060, 1'b1);
        flip = 1'b0;
        do_txn("sticky1", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'hFFFE0001, 1'b1);
        do_txn("sticky2", 16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F, 1'b1);

        // Reset in the middle of shifting (t = 7)
        a0 = 16'hABCD;
        b0 = 16'h1357;
        in_valid0 = 1'b1;
        out_ready0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst in_ready", in_ready0, 1);
        check("midrst out_valid", out_valid0, 0);
        check("midrst bit_out", bit_out0, 0);
        check("midrst product", product0, 0);
        check("midrst err", err0, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        check("midrst no result", seen, 0);
        do_txn("3x5", 16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F, 1'b0);

        // Pipelined compressor, COMP_LATENCY = 2
        check("lat2 in_ready", in_ready2, 1);
        a2 = 16'hFFFF;
        b2 = 16'hFFFF;
        in_valid2 = 1'b1;
        out_ready2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("lat2 latency", cyc, N + 3);
        check("lat2 product", product2, 32'hFFFE0001);
        check("lat2 err", err2, 0);
        @(negedge clk);
        check("lat2 out_valid drop", out_valid2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
